fft_power_spectrum: RTL and testbench

// Consumes the complex FFT output stream (real/imag, bin index, tlast), computes per-bin power
// |X|^2 = re^2 + im^2 in a 3-stage pipeline and stores bins 0..NFFT/2-1 in a ping-pong RAM.

---
 rtl/fft_power_spectrum.sv | 89 ++++++++
 tb/tb_fft_power_spectrum.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_power_spectrum.sv
// fft_power_spectrum: per-bin |X|^2 of an FFT stream into a ping-pong RAM with frame peak tracking
module fft_power_spectrum #(
  parameter int NFFT      = 1024,
  parameter int IN_W      = 32,
  parameter int PWR_W     = 32,
  parameter int PWR_SHIFT = 24,
  parameter bit SKIP_DC   = 1'b1,
  localparam int LOG2N    = $clog2(NFFT)
) (
  input  logic              i_aclk,
  input  logic              i_aresetn,
  input  logic [2*IN_W-1:0] i_fft_data,
  input  logic              i_fft_valid,
  input  logic              i_fft_last,
  input  logic [23:0]       i_fft_user,
  input  logic [LOG2N-2:0]  i_rd_addr,
  output logic [PWR_W-1:0]  o_rd_data,
  output logic              o_frame_done,
  output logic              o_frame_valid,
  output logic [LOG2N-2:0]  o_peak_bin,
  output logic [PWR_W-1:0]  o_peak_pwr,
  input  logic              i_err_clr,
  output logic              o_err_len
);
  logic [LOG2N-1:0] cnt, s1_bin, s2_bin, s3_bin;
  logic s1_v, s2_v, s3_v, s1_first, s2_first, s3_first, s1_good, s2_good, s3_good, wbank;
  logic signed [IN_W-1:0] s1_re, s1_im;
  logic signed [2*IN_W-1:0] re_x, im_x, s2_rr, s2_ii;
  logic [2*IN_W-1:0] sh;
  logic [PWR_W-1:0] s3_pwr, sat, run_pwr, base_pwr, pk_pwr;
  logic [LOG2N-2:0] run_bin, base_bin, pk_bin;
  logic good_in, err_in, elig, take, unused_user;
  logic [PWR_W-1:0] ram [NFFT];
  assign unused_user = ^i_fft_user[23:LOG2N];
  // frame length is judged at the input; the verdict then rides the pipeline with its beat
  always_comb begin
    good_in = i_fft_valid && i_fft_last && (&cnt);
    err_in = i_fft_valid && (i_fft_last ^ (&cnt));
    re_x = (2*IN_W)'(s1_re);
    im_x = (2*IN_W)'(s1_im);
    sh = (s2_rr + s2_ii) >> PWR_SHIFT;
    sat = |sh[2*IN_W-1:PWR_W] ? '1 : sh[PWR_W-1:0];
    elig = !s3_bin[LOG2N-1] && (!SKIP_DC || |s3_bin[LOG2N-2:0]);
    base_pwr = s3_first ? '0 : run_pwr;
    base_bin = s3_first ? '0 : run_bin;
    take = elig && s3_pwr > base_pwr;
    pk_pwr = take ? s3_pwr : base_pwr;
    pk_bin = take ? s3_bin[LOG2N-2:0] : base_bin;
  end
  always_ff @(posedge i_aclk or negedge i_aresetn)
    if (!i_aresetn) begin
      cnt <= '0;
      {s1_v, s2_v, s3_v, s1_first, s2_first, s3_first, s1_good, s2_good, s3_good} <= '0;
      {s1_re, s1_im, s1_bin, s2_bin, s3_bin, s2_rr, s2_ii, s3_pwr} <= '0;
      {run_pwr, run_bin, wbank} <= '0;
      {o_rd_data, o_frame_done, o_frame_valid, o_peak_bin, o_peak_pwr, o_err_len} <= '0;
    end else begin
      if (i_fft_valid) cnt <= i_fft_last ? '0 : cnt + 1'b1;
      s1_v <= i_fft_valid;
      s1_first <= cnt == '0;
      s1_good <= good_in;
      s1_re <= i_fft_data[IN_W-1:0];
      s1_im <= i_fft_data[2*IN_W-1:IN_W];
      s1_bin <= i_fft_user[LOG2N-1:0];
      s2_v <= s1_v;
      s2_first <= s1_first;
      s2_good <= s1_good;
      s2_bin <= s1_bin;
      s2_rr <= re_x * re_x;
      s2_ii <= im_x * im_x;
      s3_v <= s2_v;
      s3_first <= s2_first;
      s3_good <= s2_good;
      s3_bin <= s2_bin;
      s3_pwr <= sat;
      if (s3_v) {run_pwr, run_bin} <= {pk_pwr, pk_bin};
      o_frame_done <= s3_v && s3_good;
      if (s3_v && s3_good) begin
        wbank <= ~wbank;
        o_peak_bin <= pk_bin;
        o_peak_pwr <= pk_pwr;
        o_frame_valid <= 1'b1;
      end
      o_err_len <= i_err_clr ? 1'b0 : (o_err_len | err_in);
      o_rd_data <= ram[{~wbank, i_rd_addr}];
    end
  always_ff @(posedge i_aclk)
    if (s3_v && !s3_bin[LOG2N-1]) ram[{wbank, s3_bin[LOG2N-2:0]}] <= s3_pwr;
endmodule

// File: tb/tb_fft_power_spectrum.sv
// tb_fft_power_spectrum: randomized frames checked against a per-frame arithmetic model of power, peak and readout
module tb_fft_power_spectrum;
  localparam int NFFT = 1024, H = NFFT / 2, SH = 24;
  logic clk = 0, rst_n = 0;
  logic [63:0] i_fft_data = '0;
  logic i_fft_valid = 0, i_fft_last = 0, i_err_clr = 0;
  logic [23:0] i_fft_user = '0;
  logic [8:0] i_rd_addr = '0, o_peak_bin;
  logic [31:0] o_rd_data, o_peak_pwr;
  logic o_frame_done, o_frame_valid, o_err_len;
  fft_power_spectrum dut (
    .i_aclk(clk), .i_aresetn(rst_n), .i_fft_data(i_fft_data), .i_fft_valid(i_fft_valid),
    .i_fft_last(i_fft_last), .i_fft_user(i_fft_user), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_frame_done(o_frame_done), .o_frame_valid(o_frame_valid), .o_peak_bin(o_peak_bin),
    .o_peak_pwr(o_peak_pwr), .i_err_clr(i_err_clr), .o_err_len(o_err_len));
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  logic signed [31:0] fre [NFFT], fim [NFFT];
  logic [31:0] mdl_mem [H], nxt_mem [H], mdl_pp, nxt_pp;
  int mdl_pb, nxt_pb;
  int done_q[$], pkb_q[$];
  logic [31:0] pkp_q[$], rdd_q[$], rda_q[$];
  bit grab = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (grab) rda_q.push_back(o_rd_data);
    grab = o_frame_done;
    if (o_frame_done) begin
      done_q.push_back(cyc);
      pkb_q.push_back(int'(o_peak_bin));
      pkp_q.push_back(o_peak_pwr);
      rdd_q.push_back(o_rd_data);
    end
  end
  function automatic logic [31:0] pw(input logic signed [31:0] r, input logic signed [31:0] i);
    logic [63:0] s;
    s = 64'(longint'(r) * longint'(r)) + 64'(longint'(i) * longint'(i));
    s = s >> SH;
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction
  task automatic build_model();
    nxt_pb = 0;
    nxt_pp = 0;
    for (int b = 0; b < H; b++) begin
      nxt_mem[b] = pw(fre[b], fim[b]);
      if (b != 0 && nxt_mem[b] > nxt_pp) begin nxt_pp = nxt_mem[b]; nxt_pb = b; end
    end
  endtask
  task automatic commit();
    mdl_mem = nxt_mem;
    mdl_pp = nxt_pp;
    mdl_pb = nxt_pb;
  endtask
  task automatic qclr();
    done_q.delete(); pkb_q.delete(); pkp_q.delete(); rdd_q.delete(); rda_q.delete();
  endtask
  task automatic clear_frame();
    for (int b = 0; b < NFFT; b++) begin fre[b] = '0; fim[b] = '0; end
  endtask
  task automatic fill_rand(input int lo, input int hi);
    for (int b = 0; b < NFFT; b++) begin
      fre[b] = $signed($urandom) >>> $urandom_range(hi, lo);
      fim[b] = $signed($urandom) >>> $urandom_range(hi, lo);
    end
  endtask
  task automatic send_beats(input int n, input bit lst, input bit clr, output int t);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      i_fft_valid = 1;
      i_fft_data = {fim[b], fre[b]};
      i_fft_user = 24'(b);
      i_fft_last = lst && b == n - 1;
      i_err_clr = clr && b == n - 1;
      t = cyc;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); i_fft_valid = 0; i_fft_last = 0; i_err_clr = 0; end
  endtask
  task automatic rd(input int a, output logic [31:0] d);
    @(negedge clk);
    i_rd_addr = 9'(a);
    @(negedge clk);
    d = o_rd_data;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++; if ({o_rd_data, o_frame_done, o_frame_valid, o_peak_bin, o_peak_pwr, o_err_len} !== 76'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {o_rd_data, o_frame_done, o_frame_valid, o_peak_bin, o_peak_pwr, o_err_len}); end
    rst_n = 1;
    repeat (2) @(negedge clk);
    total++; if ({o_frame_done, o_frame_valid, o_err_len} !== 3'b000) begin
      bad++; $display("FAIL post_reset_flags got=%b exp=000", {o_frame_done, o_frame_valid, o_err_len}); end
  endtask

  task automatic test_tone();
    int t; logic [31:0] d;
    clear_frame(); fre[5] = 32'sd4096000; build_model(); qclr();
    send_beats(NFFT, 1, 0, t); idle(8);
    total++; if (done_q.size() != 1 || done_q[0] != t + 4) begin
      bad++; $display("FAIL tone_done_time got=%0d exp=%0d", done_q.size() == 1 ? done_q[0] : -1, t + 4); end
    total++; if (o_peak_bin !== 9'd5) begin bad++; $display("FAIL tone_peak_bin got=%0d exp=5", o_peak_bin); end
    total++; if (o_peak_pwr !== 32'd1000000) begin bad++; $display("FAIL tone_peak_pwr got=%0d exp=1000000", o_peak_pwr); end
    total++; if (o_frame_valid !== 1'b1) begin bad++; $display("FAIL tone_frame_valid got=%b exp=1", o_frame_valid); end
    commit();
    rd(5, d); total++; if (d !== 32'd1000000) begin bad++; $display("FAIL tone_rd5 got=%0d exp=1000000", d); end
    rd(6, d); total++; if (d !== 32'd0) begin bad++; $display("FAIL tone_rd6 got=%0d exp=0", d); end
  endtask

  task automatic test_saturation();
    int t; logic [31:0] d;
    clear_frame(); fre[3] = 32'sh80000000; fim[3] = 32'sh80000000; build_model(); qclr();
    send_beats(NFFT, 1, 0, t); idle(8);
    total++; if (done_q.size() != 1) begin bad++; $display("FAIL sat_done_count got=%0d exp=1", done_q.size()); end
    total++; if (o_peak_bin !== 9'd3 || o_peak_pwr !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL sat_peak got=%0d/%h exp=3/ffffffff", o_peak_bin, o_peak_pwr); end
    commit();
    rd(3, d); total++; if (d !== 32'hFFFFFFFF) begin bad++; $display("FAIL sat_rd3 got=%h exp=ffffffff", d); end
    rd(2, d); total++; if (d !== 32'd0) begin bad++; $display("FAIL sat_rd2 got=%h exp=0", d); end
  endtask

  task automatic test_length_error();
    int t, a; logic [31:0] d;
    fill_rand(4, 12); qclr();
    send_beats(701, 1, 0, t); idle(8);
    total++; if (o_err_len !== 1'b1) begin bad++; $display("FAIL short_err got=%b exp=1", o_err_len); end
    total++; if (done_q.size() != 0) begin bad++; $display("FAIL short_no_done got=%0d exp=0", done_q.size()); end
    total++; if (o_peak_bin !== 9'(mdl_pb) || o_peak_pwr !== mdl_pp) begin
      bad++; $display("FAIL short_peak_held got=%0d/%0d exp=%0d/%0d", o_peak_bin, o_peak_pwr, mdl_pb, mdl_pp); end
    fill_rand(4, 12); build_model(); qclr();
    send_beats(NFFT, 1, 0, t); idle(8);
    total++; if (done_q.size() != 1) begin bad++; $display("FAIL recover_done got=%0d exp=1", done_q.size()); end
    total++; if (o_peak_bin !== 9'(nxt_pb) || o_peak_pwr !== nxt_pp) begin
      bad++; $display("FAIL recover_peak got=%0d/%0d exp=%0d/%0d", o_peak_bin, o_peak_pwr, nxt_pb, nxt_pp); end
    total++; if (o_err_len !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", o_err_len); end
    commit();
    @(negedge clk); i_err_clr = 1; @(negedge clk); i_err_clr = 0; @(negedge clk);
    total++; if (o_err_len !== 1'b0) begin bad++; $display("FAIL err_clr got=%b exp=0", o_err_len); end
    for (int b = 0; b < NFFT; b++) begin fre[b] = 32'sh40000000; fim[b] = 32'sh40000000; end
    qclr();
    send_beats(NFFT, 0, 1, t);
    fill_rand(4, 12); build_model();
    send_beats(NFFT, 1, 0, t); idle(8);
    total++; if (o_err_len !== 1'b0) begin bad++; $display("FAIL clr_priority got=%b exp=0", o_err_len); end
    total++; if (done_q.size() != 1 || done_q[0] != t + 4) begin
      bad++; $display("FAIL resync_done got=%0d exp=%0d", done_q.size() == 1 ? done_q[0] : -1, t + 4); end
    total++; if (o_peak_bin !== 9'(nxt_pb) || o_peak_pwr !== nxt_pp) begin
      bad++; $display("FAIL resync_peak got=%0d/%0d exp=%0d/%0d", o_peak_bin, o_peak_pwr, nxt_pb, nxt_pp); end
    commit();
    a = $urandom_range(H - 1, 1);
    rd(a, d); total++; if (d !== mdl_mem[a]) begin bad++; $display("FAIL resync_rd%0d got=%0d exp=%0d", a, d, mdl_mem[a]); end
    send_beats(10, 1, 0, t); idle(8);
    total++; if (o_err_len !== 1'b1) begin bad++; $display("FAIL err_reset got=%b exp=1", o_err_len); end
  endtask

  task automatic test_back_to_back();
    int t; logic [31:0] prev10, a10, apw;
    prev10 = mdl_mem[10];
    clear_frame(); fre[10] = 32'sd8000000; build_model(); a10 = nxt_mem[10]; apw = nxt_pp; qclr();
    i_rd_addr = 9'd10;
    send_beats(NFFT, 1, 0, t);
    clear_frame(); fre[10] = 32'sd2000000; fre[20] = 32'sd9000000; build_model();
    send_beats(NFFT, 1, 0, t); idle(8);
    total++; if (done_q.size() != 2 || rda_q.size() != 2) begin
      bad++; $display("FAIL b2b_done_count got=%0d exp=2", done_q.size());
    end else begin
      total++; if (done_q[1] - done_q[0] != NFFT) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", done_q[1] - done_q[0], NFFT); end
      total++; if (pkb_q[0] != 10 || pkp_q[0] !== apw) begin bad++; $display("FAIL b2b_peak0 got=%0d/%0d exp=10/%0d", pkb_q[0], pkp_q[0], apw); end
      total++; if (pkb_q[1] != 20 || pkp_q[1] !== nxt_pp) begin bad++; $display("FAIL b2b_peak1 got=%0d/%0d exp=20/%0d", pkb_q[1], pkp_q[1], nxt_pp); end
      total++; if (rdd_q[0] !== prev10) begin bad++; $display("FAIL b2b_rd_before got=%0d exp=%0d", rdd_q[0], prev10); end
      total++; if (rda_q[0] !== a10) begin bad++; $display("FAIL b2b_rd_frame0 got=%0d exp=%0d", rda_q[0], a10); end
      total++; if (rda_q[1] !== nxt_mem[10]) begin bad++; $display("FAIL b2b_rd_frame1 got=%0d exp=%0d", rda_q[1], nxt_mem[10]); end
    end
    commit();
  endtask

  task automatic test_tie_dc();
    int t; logic [31:0] d;
    clear_frame();
    fre[0] = 32'sh80000000; fre[7] = 32'sd3000000; fre[9] = 32'sd3000000;
    fre[519] = 32'sh80000000; fre[600] = 32'sh7fffffff;
    build_model(); qclr();
    send_beats(NFFT, 1, 0, t); idle(8);
    total++; if (o_peak_bin !== 9'd7) begin bad++; $display("FAIL tie_peak_bin got=%0d exp=7", o_peak_bin); end
    total++; if (o_peak_pwr !== pw(32'sd3000000, 32'sd0)) begin bad++; $display("FAIL tie_peak_pwr got=%0d exp=%0d", o_peak_pwr, pw(32'sd3000000, 32'sd0)); end
    commit();
    rd(0, d); total++; if (d !== 32'hFFFFFFFF) begin bad++; $display("FAIL dc_stored got=%h exp=ffffffff", d); end
    rd(7, d); total++; if (d !== mdl_mem[7]) begin bad++; $display("FAIL upper_alias got=%0d exp=%0d", d, mdl_mem[7]); end
  endtask

  task automatic test_async_reset();
    int t; logic [31:0] d;
    fill_rand(4, 12); qclr();
    send_beats(300, 0, 0, t);
    #2 rst_n = 0; i_fft_valid = 0;
    @(negedge clk);
    total++; if ({o_rd_data, o_frame_done, o_frame_valid, o_peak_bin, o_peak_pwr, o_err_len} !== 76'd0) begin
      bad++; $display("FAIL areset_outputs got=%h exp=0", {o_rd_data, o_frame_done, o_frame_valid, o_peak_bin, o_peak_pwr, o_err_len}); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    fill_rand(4, 12); build_model();
    send_beats(NFFT, 1, 0, t); idle(8);
    total++; if (done_q.size() != 1 || done_q[0] != t + 4) begin
      bad++; $display("FAIL areset_done got=%0d exp=%0d", done_q.size() == 1 ? done_q[0] : -1, t + 4); end
    total++; if (o_peak_bin !== 9'(nxt_pb) || o_peak_pwr !== nxt_pp || o_frame_valid !== 1'b1) begin
      bad++; $display("FAIL areset_peak got=%0d/%0d exp=%0d/%0d", o_peak_bin, o_peak_pwr, nxt_pb, nxt_pp); end
    commit();
    rd(nxt_pb, d); total++; if (d !== mdl_mem[mdl_pb]) begin bad++; $display("FAIL areset_rd got=%0d exp=%0d", d, mdl_mem[mdl_pb]); end
  endtask

  task automatic test_random();
    int t, a; logic [31:0] d;
    repeat (3) begin
      fill_rand(0, 12); build_model(); qclr();
      send_beats(NFFT, 1, 0, t); idle(8);
      total++; if (done_q.size() != 1 || o_peak_bin !== 9'(nxt_pb) || o_peak_pwr !== nxt_pp) begin
        bad++; $display("FAIL rand_peak got=%0d/%0d exp=%0d/%0d", o_peak_bin, o_peak_pwr, nxt_pb, nxt_pp); end
      commit();
      repeat (6) begin
        a = $urandom_range(H - 1, 0);
        rd(a, d); total++; if (d !== mdl_mem[a]) begin bad++; $display("FAIL rand_rd%0d got=%0d exp=%0d", a, d, mdl_mem[a]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tone();
    test_saturation();
    test_length_error();
    test_back_to_back();
    test_tie_dc();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
